// File: rtl/ysyx_23060061_trap_ctrl_pkg.sv
// Shared encodings for the trap/CSR sequencer: Zicsr funct3 values, machine CSR numbers, FSM states.
package ysyx_23060061_trap_ctrl_pkg;

  localparam logic [2:0] F3_RW  = 3'b001;
  localparam logic [2:0] F3_RS  = 3'b010;
  localparam logic [2:0] F3_RC  = 3'b011;
  localparam logic [2:0] F3_RWI = 3'b101;
  localparam logic [2:0] F3_RSI = 3'b110;
  localparam logic [2:0] F3_RCI = 3'b111;

  localparam logic [11:0] CSR_MSTATUS = 12'h300;
  localparam logic [11:0] CSR_MTVEC   = 12'h305;
  localparam logic [11:0] CSR_MEPC    = 12'h341;
  localparam logic [11:0] CSR_MCAUSE  = 12'h342;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_READ  = 3'd1;
  localparam logic [2:0] ST_WRITE = 3'd2;
  localparam logic [2:0] ST_TRAP  = 3'd3;
  localparam logic [2:0] ST_MRET  = 3'd4;
  localparam logic [2:0] ST_RESP  = 3'd5;

  function automatic logic csr_implemented(input logic [11:0] addr);
    logic hit;
    case (addr)
      CSR_MSTATUS, CSR_MTVEC, CSR_MEPC, CSR_MCAUSE: hit = 1'b1;
      default: hit = 1'b0;
    endcase
    return hit;
  endfunction

  function automatic logic funct3_legal(input logic [2:0] f3);
    logic ok;
    case (f3)
      F3_RW, F3_RS, F3_RC, F3_RWI, F3_RSI, F3_RCI: ok = 1'b1;
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/ysyx_23060061_csr_alu.sv
// Zicsr new-value computation: write/set/clear of the old CSR value by a register or zimm source.
module ysyx_23060061_csr_alu
  import ysyx_23060061_trap_ctrl_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] old,
  input  logic [XLEN-1:0] src,
  input  logic            rs1_zero,
  output logic [XLEN-1:0] wdata,
  output logic            wr_en
);

  // Set/clear with x0 (or zimm 0) must not write, so side-effect-free CSR reads stay reads.
  always_comb begin
    wdata = {XLEN{1'b0}};
    wr_en = 1'b0;
    case (funct3)
      F3_RW, F3_RWI: begin
        wdata = src;
        wr_en = 1'b1;
      end
      F3_RS, F3_RSI: begin
        wdata = old | src;
        wr_en = ~rs1_zero;
      end
      F3_RC, F3_RCI: begin
        wdata = old & ~src;
        wr_en = ~rs1_zero;
      end
      default: begin
        wdata = {XLEN{1'b0}};
        wr_en = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/ysyx_23060061_trap_ctrl.sv
// Sequencer between execute and the machine CSR file: multi-cycle Zicsr RMW, ecall and mret,
// returning rd data and a PC redirect over a valid/ready handshake.
module ysyx_23060061_trap_ctrl
  import ysyx_23060061_trap_ctrl_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2:0]      in_funct3,
  input  logic            in_ecall,
  input  logic            in_mret,
  input  logic [11:0]     in_csr_addr,
  input  logic [4:0]      in_rs1_idx,
  input  logic [XLEN-1:0] in_rs1_data,
  input  logic [XLEN-1:0] in_pc,
  output logic            csr_en,
  output logic [11:0]     csr_id,
  output logic [XLEN-1:0] csr_wdata,
  input  logic [XLEN-1:0] csr_rdata,
  output logic            csr_ecall,
  output logic [XLEN-1:0] csr_pc,
  input  logic [XLEN-1:0] csr_mtvec,
  input  logic [XLEN-1:0] csr_mepc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_rd_data,
  output logic            out_redirect,
  output logic [XLEN-1:0] out_redir_pc,
  output logic            out_illegal
);

  logic [2:0]      state_r, state_s;
  logic [2:0]      funct3_r;
  logic [11:0]     addr_r;
  logic [XLEN-1:0] src_r, old_r;
  logic            rs1_zero_r, illegal_r;
  logic            accept_s;

  logic            in_ready_r, in_ready_s;
  logic            csr_en_r, csr_en_s, csr_ecall_r, csr_ecall_s;
  logic [11:0]     csr_id_r, csr_id_s;
  logic [XLEN-1:0] csr_wdata_r, csr_wdata_s, csr_pc_r, csr_pc_s;
  logic            out_valid_r, out_valid_s, out_redirect_r, out_redirect_s;
  logic            out_illegal_r, out_illegal_s;
  logic [XLEN-1:0] out_rd_data_r, out_rd_data_s, out_redir_pc_r, out_redir_pc_s;

  logic [XLEN-1:0] alu_wdata_s;
  logic            alu_wr_en_s;

  ysyx_23060061_csr_alu #(.XLEN(XLEN)) u_alu (
    .funct3   (funct3_r),
    .old      (csr_rdata),
    .src      (src_r),
    .rs1_zero (rs1_zero_r),
    .wdata    (alu_wdata_s),
    .wr_en    (alu_wr_en_s)
  );

  assign accept_s = in_valid & in_ready_r;

  // Next-state and next-output decode; CSR strobes default low so they only ever pulse once.
  always_comb begin
    state_s        = state_r;
    in_ready_s     = 1'b0;
    csr_en_s       = 1'b0;
    csr_ecall_s    = 1'b0;
    csr_id_s       = 12'h000;
    csr_wdata_s    = {XLEN{1'b0}};
    csr_pc_s       = {XLEN{1'b0}};
    out_valid_s    = out_valid_r;
    out_rd_data_s  = out_rd_data_r;
    out_redirect_s = out_redirect_r;
    out_redir_pc_s = out_redir_pc_r;
    out_illegal_s  = out_illegal_r;
    case (state_r)
      ST_IDLE: begin
        if (accept_s) begin
          if (in_ecall) begin
            state_s     = ST_TRAP;
            csr_ecall_s = 1'b1;
            csr_pc_s    = in_pc;
          end else if (in_mret) begin
            state_s = ST_MRET;
          end else if (funct3_legal(in_funct3) && csr_implemented(in_csr_addr)) begin
            state_s  = ST_READ;
            csr_id_s = in_csr_addr;
          end else begin
            state_s  = ST_WRITE;
            csr_id_s = in_csr_addr;
          end
        end else begin
          in_ready_s = 1'b1;
        end
      end
      ST_READ: begin
        state_s     = ST_WRITE;
        csr_id_s    = addr_r;
        csr_en_s    = alu_wr_en_s;
        csr_wdata_s = alu_wdata_s;
      end
      ST_WRITE: begin
        state_s        = ST_RESP;
        out_valid_s    = 1'b1;
        out_rd_data_s  = illegal_r ? {XLEN{1'b0}} : old_r;
        out_redirect_s = 1'b0;
        out_redir_pc_s = {XLEN{1'b0}};
        out_illegal_s  = illegal_r;
      end
      ST_TRAP: begin
        state_s        = ST_RESP;
        out_valid_s    = 1'b1;
        out_rd_data_s  = {XLEN{1'b0}};
        out_redirect_s = 1'b1;
        out_redir_pc_s = csr_mtvec;
        out_illegal_s  = 1'b0;
      end
      ST_MRET: begin
        state_s        = ST_RESP;
        out_valid_s    = 1'b1;
        out_rd_data_s  = {XLEN{1'b0}};
        out_redirect_s = 1'b1;
        out_redir_pc_s = csr_mepc;
        out_illegal_s  = 1'b0;
      end
      ST_RESP: begin
        if (out_ready) begin
          state_s        = ST_IDLE;
          in_ready_s     = 1'b1;
          out_valid_s    = 1'b0;
          out_rd_data_s  = {XLEN{1'b0}};
          out_redirect_s = 1'b0;
          out_redir_pc_s = {XLEN{1'b0}};
          out_illegal_s  = 1'b0;
        end else begin
          state_s = ST_RESP;
        end
      end
      default: begin
        state_s        = ST_IDLE;
        in_ready_s     = 1'b1;
        out_valid_s    = 1'b0;
        out_rd_data_s  = {XLEN{1'b0}};
        out_redirect_s = 1'b0;
        out_redir_pc_s = {XLEN{1'b0}};
        out_illegal_s  = 1'b0;
      end
    endcase
  end

  // State and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r        <= ST_IDLE;
      in_ready_r     <= 1'b1;
      csr_en_r       <= 1'b0;
      csr_ecall_r    <= 1'b0;
      csr_id_r       <= 12'h000;
      csr_wdata_r    <= {XLEN{1'b0}};
      csr_pc_r       <= {XLEN{1'b0}};
      out_valid_r    <= 1'b0;
      out_rd_data_r  <= {XLEN{1'b0}};
      out_redirect_r <= 1'b0;
      out_redir_pc_r <= {XLEN{1'b0}};
      out_illegal_r  <= 1'b0;
    end else begin
      state_r        <= state_s;
      in_ready_r     <= in_ready_s;
      csr_en_r       <= csr_en_s;
      csr_ecall_r    <= csr_ecall_s;
      csr_id_r       <= csr_id_s;
      csr_wdata_r    <= csr_wdata_s;
      csr_pc_r       <= csr_pc_s;
      out_valid_r    <= out_valid_s;
      out_rd_data_r  <= out_rd_data_s;
      out_redirect_r <= out_redirect_s;
      out_redir_pc_r <= out_redir_pc_s;
      out_illegal_r  <= out_illegal_s;
    end
  end

  // Request fields latched at the accept edge; old CSR value captured during READ.
  always_ff @(posedge clk) begin
    if (rst) begin
      funct3_r   <= 3'b000;
      addr_r     <= 12'h000;
      src_r      <= {XLEN{1'b0}};
      rs1_zero_r <= 1'b0;
      illegal_r  <= 1'b0;
      old_r      <= {XLEN{1'b0}};
    end else if (accept_s) begin
      funct3_r   <= in_funct3;
      addr_r     <= in_csr_addr;
      src_r      <= in_funct3[2] ? {{(XLEN-5){1'b0}}, in_rs1_idx} : in_rs1_data;
      rs1_zero_r <= (in_rs1_idx == 5'd0);
      illegal_r  <= ~in_ecall & ~in_mret &
                    ~(funct3_legal(in_funct3) & csr_implemented(in_csr_addr));
      old_r      <= old_r;
    end else if (state_r == ST_READ) begin
      old_r <= csr_rdata;
    end else begin
      old_r <= old_r;
    end
  end

  // Strobes are masked by rst so a reset landing on WRITE/TRAP never reaches the CSR file.
  assign csr_en       = csr_en_r & ~rst;
  assign csr_ecall    = csr_ecall_r & ~rst;
  assign in_ready     = in_ready_r;
  assign csr_id       = csr_id_r;
  assign csr_wdata    = csr_wdata_r;
  assign csr_pc       = csr_pc_r;
  assign out_valid    = out_valid_r;
  assign out_rd_data  = out_rd_data_r;
  assign out_redirect = out_redirect_r;
  assign out_redir_pc = out_redir_pc_r;
  assign out_illegal  = out_illegal_r;

endmodule

// File: tb/tb_ysyx_23060061_trap_ctrl.sv
// Directed bench for ysyx_23060061_trap_ctrl: Zicsr, ecall, mret, illegal, back-pressure and reset abort.
module tb_ysyx_23060061_trap_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0, in_ecall = 1'b0, in_mret = 1'b0, out_ready = 1'b0;
  logic [2:0]  in_funct3 = 3'b000;
  logic [11:0] in_csr_addr = 12'h000;
  logic [4:0]  in_rs1_idx = 5'd0;
  logic [31:0] in_rs1_data = 32'h0, in_pc = 32'h0;
  logic        in_ready, csr_en, csr_ecall, out_valid, out_redirect, out_illegal;
  logic [11:0] csr_id;
  logic [31:0] csr_wdata, csr_rdata, csr_pc, csr_mtvec, csr_mepc;
  logic [31:0] out_rd_data, out_redir_pc;

  logic [31:0] csr_val = 32'h0, mtvec_val = 32'h0, mepc_val = 32'h0;
  assign csr_rdata = csr_val;
  assign csr_mtvec = mtvec_val;
  assign csr_mepc  = mepc_val;

  always #5 clk = ~clk;

  ysyx_23060061_trap_ctrl #(.XLEN(32)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_funct3(in_funct3),
    .in_ecall(in_ecall), .in_mret(in_mret), .in_csr_addr(in_csr_addr), .in_rs1_idx(in_rs1_idx),
    .in_rs1_data(in_rs1_data), .in_pc(in_pc), .csr_en(csr_en), .csr_id(csr_id),
    .csr_wdata(csr_wdata), .csr_rdata(csr_rdata), .csr_ecall(csr_ecall), .csr_pc(csr_pc),
    .csr_mtvec(csr_mtvec), .csr_mepc(csr_mepc), .out_valid(out_valid), .out_ready(out_ready),
    .out_rd_data(out_rd_data), .out_redirect(out_redirect), .out_redir_pc(out_redir_pc),
    .out_illegal(out_illegal)
  );

  int n_checks = 0;
  int n_fail = 0;
  int en_cnt, en_cyc, ec_cnt, ec_cyc, lat;
  logic [31:0] en_wdata, en_id, ec_pc;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Present one request, then watch up to 8 cycles after the accept edge for strobes and out_valid.
  task automatic do_req(input logic ec, input logic mr, input logic [2:0] f3,
                        input logic [11:0] addr, input logic [4:0] idx,
                        input logic [31:0] rs1, input logic [31:0] pc);
    logic got;
    @(negedge clk);
    check_eq("in_ready_idle", in_ready, 32'd1);
    in_valid = 1'b1; in_ecall = ec; in_mret = mr; in_funct3 = f3;
    in_csr_addr = addr; in_rs1_idx = idx; in_rs1_data = rs1; in_pc = pc;
    @(posedge clk);
    #1;
    in_valid = 1'b0; in_ecall = 1'b0; in_mret = 1'b0; in_funct3 = 3'b000;
    in_csr_addr = 12'h000; in_rs1_idx = 5'd0; in_rs1_data = 32'hDEADBEEF; in_pc = 32'hDEADBEEF;
    en_cnt = 0; en_cyc = 0; ec_cnt = 0; ec_cyc = 0; lat = 0; got = 1'b0;
    en_wdata = 32'h0; en_id = 32'h0; ec_pc = 32'h0;
    for (int c = 1; c <= 8 && !got; c++) begin
      @(negedge clk);
      if (csr_en) begin en_cnt++; en_cyc = c; en_wdata = csr_wdata; en_id = {20'h0, csr_id}; end
      if (csr_ecall) begin ec_cnt++; ec_cyc = c; ec_pc = csr_pc; end
      if (out_valid) begin got = 1'b1; lat = c; end
    end
    if (!got) check_eq("out_valid_timeout", 32'd0, 32'd1);
  endtask

  task automatic finish_resp();
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    @(negedge clk);
    check_eq("post_hs_out_valid", out_valid, 32'd0);
    check_eq("post_hs_in_ready", in_ready, 32'd1);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_eq("rst_in_ready", in_ready, 32'd1);
    check_eq("rst_out_valid", out_valid, 32'd0);
    check_eq("rst_csr_en", csr_en, 32'd0);
    check_eq("rst_csr_ecall", csr_ecall, 32'd0);
    check_eq("rst_csr_id", {20'h0, csr_id}, 32'd0);
    check_eq("rst_rd_data", out_rd_data, 32'd0);

    // CSRRW mtvec, x5
    csr_val = 32'h0;
    do_req(1'b0, 1'b0, 3'b001, 12'h305, 5'd5, 32'h80000100, 32'h0);
    check_eq("rw_en_cnt", en_cnt, 32'd1);
    check_eq("rw_en_cyc", en_cyc, 32'd2);
    check_eq("rw_wdata", en_wdata, 32'h80000100);
    check_eq("rw_id", en_id, 32'h305);
    check_eq("rw_lat", lat, 32'd3);
    check_eq("rw_rd", out_rd_data, 32'h0);
    check_eq("rw_redirect", out_redirect, 32'd0);
    check_eq("rw_illegal", out_illegal, 32'd0);
    finish_resp();

    // CSRRS mstatus, x0: read only
    csr_val = 32'h1800;
    do_req(1'b0, 1'b0, 3'b010, 12'h300, 5'd0, 32'hFFFFFFFF, 32'h0);
    check_eq("rs0_en_cnt", en_cnt, 32'd0);
    check_eq("rs0_lat", lat, 32'd3);
    check_eq("rs0_rd", out_rd_data, 32'h1800);
    finish_resp();

    // CSRRCI mstatus, 8
    csr_val = 32'h1888;
    do_req(1'b0, 1'b0, 3'b111, 12'h300, 5'd8, 32'hFFFFFFFF, 32'h0);
    check_eq("rci_en_cnt", en_cnt, 32'd1);
    check_eq("rci_wdata", en_wdata, 32'h1880);
    check_eq("rci_rd", out_rd_data, 32'h1888);
    finish_resp();

    // ecall
    mtvec_val = 32'h80000200;
    do_req(1'b1, 1'b0, 3'b000, 12'h000, 5'd0, 32'h0, 32'h80000040);
    check_eq("ecall_strobe_cnt", ec_cnt, 32'd1);
    check_eq("ecall_strobe_cyc", ec_cyc, 32'd1);
    check_eq("ecall_pc", ec_pc, 32'h80000040);
    check_eq("ecall_en_cnt", en_cnt, 32'd0);
    check_eq("ecall_lat", lat, 32'd2);
    check_eq("ecall_redirect", out_redirect, 32'd1);
    check_eq("ecall_redir_pc", out_redir_pc, 32'h80000200);
    check_eq("ecall_rd", out_rd_data, 32'h0);
    finish_resp();

    // mret
    mepc_val = 32'h80000040;
    do_req(1'b0, 1'b1, 3'b001, 12'h305, 5'd5, 32'h1234, 32'h0);
    check_eq("mret_en_cnt", en_cnt, 32'd0);
    check_eq("mret_ecall_cnt", ec_cnt, 32'd0);
    check_eq("mret_lat", lat, 32'd2);
    check_eq("mret_redirect", out_redirect, 32'd1);
    check_eq("mret_redir_pc", out_redir_pc, 32'h80000040);
    finish_resp();

    // ecall wins over mret
    do_req(1'b1, 1'b1, 3'b000, 12'h000, 5'd0, 32'h0, 32'h80000044);
    check_eq("prio_ecall_cnt", ec_cnt, 32'd1);
    check_eq("prio_redir_pc", out_redir_pc, 32'h80000200);
    finish_resp();

    // unimplemented CSR
    csr_val = 32'h55;
    do_req(1'b0, 1'b0, 3'b001, 12'h7C0, 5'd5, 32'h1, 32'h0);
    check_eq("badcsr_en_cnt", en_cnt, 32'd0);
    check_eq("badcsr_lat", lat, 32'd2);
    check_eq("badcsr_illegal", out_illegal, 32'd1);
    check_eq("badcsr_rd", out_rd_data, 32'h0);
    finish_resp();

    // reserved funct3
    do_req(1'b0, 1'b0, 3'b100, 12'h300, 5'd5, 32'h1, 32'h0);
    check_eq("badf3_en_cnt", en_cnt, 32'd0);
    check_eq("badf3_illegal", out_illegal, 32'd1);
    finish_resp();

    // CSRRS mepc with back-pressure
    csr_val = 32'h100;
    do_req(1'b0, 1'b0, 3'b010, 12'h341, 5'd7, 32'h0F, 32'h0);
    check_eq("rs_wdata", en_wdata, 32'h10F);
    check_eq("rs_rd", out_rd_data, 32'h100);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check_eq("stall_out_valid", out_valid, 32'd1);
      check_eq("stall_rd", out_rd_data, 32'h100);
      check_eq("stall_in_ready", in_ready, 32'd0);
    end
    finish_resp();

    // reset lands on the WRITE cycle
    @(negedge clk);
    in_valid = 1'b1; in_funct3 = 3'b001; in_csr_addr = 12'h305; in_rs1_idx = 5'd5;
    in_rs1_data = 32'h1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    check_eq("rstw_csr_en", csr_en, 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_eq("rstw_in_ready", in_ready, 32'd1);
    check_eq("rstw_out_valid", out_valid, 32'd0);
    check_eq("rstw_csr_en_after", csr_en, 32'd0);

    // recovery after abort
    csr_val = 32'h7;
    do_req(1'b0, 1'b0, 3'b101, 12'h342, 5'd3, 32'h0, 32'h0);
    check_eq("rwi_wdata", en_wdata, 32'h3);
    check_eq("rwi_rd", out_rd_data, 32'h7);
    finish_resp();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
